uart_program_loader: RTL and testbench

CPU-side boot loader between the core's UART_RX/UART_TX pair and the instruction memory write port. After reset it announces readiness with 0x99 and receives a 4-byte little-endian program length. It then receives that many program bytes, packs them little-endian into 32-bit words and writes them to instruction memory. Finally it answers 0xAA and asserts `cpu_run`, handing the UART and the core over to the program.

---
 rtl/uart_program_loader.sv | 232 +++++++++++++++++++++++
 tb/tb_uart_program_loader.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_program_loader.sv
// uart_program_loader: boot loader sitting between UART_RX/UART_TX and the
// instruction memory write port. Sends 0x99, receives a 32-bit little-endian
// length, streams that many bytes into memory as little-endian words, then
// sends 0xAA and releases the core via cpu_run.
//
// Optional feature: define LOADER_CHECKSUM_EN to require one trailing byte
// equal to the XOR of all program bytes before 0xAA is sent.
module uart_program_loader #(
   parameter int unsigned IMEM_ADDR_W    = 13,
   parameter int unsigned MAX_PROG_BYTES = 4 << IMEM_ADDR_W
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic [7:0]             rx_data,
   input  logic                   rx_valid,
   input  logic                   rx_ferr,
   output logic [7:0]             tx_data,
   output logic                   tx_start,
   input  logic                   tx_busy,
   output logic                   imem_we,
   output logic [IMEM_ADDR_W-1:0] imem_addr,
   output logic [31:0]            imem_wdata,
   output logic                   cpu_run,
   output logic                   load_error
);

   localparam logic [7:0] ReadyByte = 8'h99;
   localparam logic [7:0] DoneByte  = 8'hAA;

`ifdef LOADER_CHECKSUM_EN
   typedef enum logic [2:0] {
      StSend99, StRecvSize, StRecvProg, StCheck, StSendAa, StRun, StError
   } state_e;
   // Every completed image, including an empty one, passes through the checksum byte.
   localparam state_e StAfterProg = StCheck;
`else
   typedef enum logic [2:0] {
      StSend99, StRecvSize, StRecvProg, StSendAa, StRun, StError
   } state_e;
   localparam state_e StAfterProg = StSendAa;
`endif

   state_e                 state_q, state_d;
   logic [31:0]            cnt_q, cnt_d;
   logic [31:0]            len_q, len_d;
   logic [31:0]            word_q, word_d;
   logic [31:0]            merged_word;
   logic [31:0]            len_next;
   logic                   sent_q, sent_d;
   logic                   guard_q, guard_d;
   logic                   tx_start_q, tx_start_d;
   logic [7:0]             tx_data_q, tx_data_d;
   logic                   imem_we_q, imem_we_d;
   logic [IMEM_ADDR_W-1:0] imem_addr_q, imem_addr_d;
   logic [31:0]            imem_wdata_q, imem_wdata_d;
`ifdef LOADER_CHECKSUM_EN
   logic [7:0]             xsum_q, xsum_d;
`endif

   logic rx_ok, rx_bad;
   logic lane_last, prog_last, word_done;
   logic in_tx_state, tx_fire, tx_done;

   assign rx_ok       = rx_valid & ~rx_ferr;
   assign rx_bad      = rx_valid & rx_ferr;
   // Length bytes arrive LSB first, so shift each new byte in from the top.
   assign len_next    = {rx_data, len_q[31:8]};
   assign lane_last   = (cnt_q[1:0] == 2'd3);
   assign prog_last   = ((cnt_q + 32'd1) == len_q);
   assign word_done   = lane_last | prog_last;
   assign in_tx_state = (state_q == StSend99) | (state_q == StSendAa);
   // guard_q hides tx_busy during the tx_start cycle, before UART_TX has reacted.
   assign tx_fire     = in_tx_state & ~sent_q & ~guard_q & ~tx_busy;
   assign tx_done     = in_tx_state & sent_q & ~guard_q & ~tx_busy;

   // Current word with the incoming byte dropped into its lane.
   always_comb begin
      merged_word = word_q;
      merged_word[{cnt_q[1:0], 3'b000} +: 8] = rx_data;
   end

   // State register.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q <= StSend99;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StSend99: begin
            if (tx_done) state_d = StRecvSize;
         end
         StRecvSize: begin
            if (rx_bad) begin
               state_d = StError;
            end else if (rx_ok && lane_last) begin
               if (len_next == 32'd0) begin
                  state_d = StAfterProg;
               end else if (len_next > MAX_PROG_BYTES) begin
                  state_d = StError;
               end else begin
                  state_d = StRecvProg;
               end
            end
         end
         StRecvProg: begin
            if (rx_bad) begin
               state_d = StError;
            end else if (rx_ok && prog_last) begin
               state_d = StAfterProg;
            end
         end
`ifdef LOADER_CHECKSUM_EN
         StCheck: begin
            if (rx_bad) begin
               state_d = StError;
            end else if (rx_ok) begin
               state_d = (rx_data == xsum_q) ? StSendAa : StError;
            end
         end
`endif
         StSendAa: begin
            if (tx_done) state_d = StRun;
         end
         StRun, StError: begin
            state_d = state_q;
         end
         default: begin
            state_d = StError;
         end
      endcase
   end

   // Outputs decoded from the state register.
   always_comb begin
      cpu_run    = (state_q == StRun);
      load_error = (state_q == StError);
   end

   assign tx_start   = tx_start_q;
   assign tx_data    = tx_data_q;
   assign imem_we    = imem_we_q;
   assign imem_addr  = imem_addr_q;
   assign imem_wdata = imem_wdata_q;

   // Datapath next-state: transmit handshake, length capture, word packing.
   always_comb begin
      cnt_d        = cnt_q;
      len_d        = len_q;
      word_d       = word_q;
      sent_d       = sent_q;
      guard_d      = 1'b0;
      tx_start_d   = 1'b0;
      tx_data_d    = tx_data_q;
      imem_we_d    = 1'b0;
      imem_addr_d  = imem_addr_q;
      imem_wdata_d = imem_wdata_q;
`ifdef LOADER_CHECKSUM_EN
      xsum_d       = xsum_q;
`endif

      if (tx_fire) begin
         tx_start_d = 1'b1;
         tx_data_d  = (state_q == StSend99) ? ReadyByte : DoneByte;
         sent_d     = 1'b1;
         guard_d    = 1'b1;
      end else if (tx_done) begin
         sent_d = 1'b0;
      end

      if (state_q == StRecvSize && rx_ok) begin
         len_d = len_next;
         // Counter restarts at zero so it can count program bytes next.
         cnt_d = lane_last ? 32'd0 : (cnt_q + 32'd1);
      end

      if (state_q == StRecvProg && rx_ok) begin
         cnt_d = cnt_q + 32'd1;
`ifdef LOADER_CHECKSUM_EN
         xsum_d = xsum_q ^ rx_data;
`endif
         if (word_done) begin
            imem_we_d    = 1'b1;
            imem_addr_d  = cnt_q[IMEM_ADDR_W+1:2];
            imem_wdata_d = merged_word;
            // Cleared lanes make a short final word zero-filled.
            word_d       = 32'd0;
         end else begin
            word_d = merged_word;
         end
      end
   end

   // Datapath registers.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         cnt_q        <= 32'd0;
         len_q        <= 32'd0;
         word_q       <= 32'd0;
         sent_q       <= 1'b0;
         guard_q      <= 1'b0;
         tx_start_q   <= 1'b0;
         tx_data_q    <= 8'd0;
         imem_we_q    <= 1'b0;
         imem_addr_q  <= '0;
         imem_wdata_q <= 32'd0;
`ifdef LOADER_CHECKSUM_EN
         xsum_q       <= 8'd0;
`endif
      end else begin
         cnt_q        <= cnt_d;
         len_q        <= len_d;
         word_q       <= word_d;
         sent_q       <= sent_d;
         guard_q      <= guard_d;
         tx_start_q   <= tx_start_d;
         tx_data_q    <= tx_data_d;
         imem_we_q    <= imem_we_d;
         imem_addr_q  <= imem_addr_d;
         imem_wdata_q <= imem_wdata_d;
`ifdef LOADER_CHECKSUM_EN
         xsum_q       <= xsum_d;
`endif
      end
   end

endmodule

// File: tb/tb_uart_program_loader.sv
// Bench for uart_program_loader: directed images, an image-level model of the
// expected tx bytes and memory writes, and a per-cycle compare process.
// LOADER_CHECKSUM_EN selects the checksum variant, matching the RTL build.
module tb_uart_program_loader;

   localparam int unsigned AW   = 13;
   localparam int unsigned MAXB = 4 << AW;
   localparam int          BusyCycles = 5;

   logic          clk      = 1'b0;
   logic          reset_n  = 1'b0;
   logic [7:0]    rx_data  = 8'd0;
   logic          rx_valid = 1'b0;
   logic          rx_ferr  = 1'b0;
   logic          tx_busy  = 1'b0;
   logic [7:0]    tx_data;
   logic          tx_start;
   logic          imem_we;
   logic [AW-1:0] imem_addr;
   logic [31:0]   imem_wdata;
   logic          cpu_run;
   logic          load_error;

   uart_program_loader #(
      .IMEM_ADDR_W   (AW),
      .MAX_PROG_BYTES(MAXB)
   ) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .rx_ferr   (rx_ferr),
      .tx_data   (tx_data),
      .tx_start  (tx_start),
      .tx_busy   (tx_busy),
      .imem_we   (imem_we),
      .imem_addr (imem_addr),
      .imem_wdata(imem_wdata),
      .cpu_run   (cpu_run),
      .load_error(load_error)
   );

   always #5 clk = ~clk;

   int          vectors     = 0;
   int          miscompares = 0;
   bit          mon_on = 1'b0;
   bit          run_exp = 1'b0;
   bit          err_exp = 1'b0;
   bit          expect_success = 1'b0;
   bit          busy_pend = 1'b0;
   int          busy_left = 0;
   int          tx_count = 0;
   logic [7:0]  exp_tx[$];
   int          exp_waddr[$];
   logic [31:0] exp_wdata[$];
   logic [31:0] mem[int];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic flag(input string name, input string what);
      vectors++;
      miscompares++;
      $display("FAIL %s: %s", name, what);
   endtask

   // Compare process (1 time unit after each edge) plus the UART_TX model.
   always @(posedge clk) begin
      #1;
      if (mon_on) begin
         check("cpu_run", 32'(cpu_run), 32'(run_exp));
         check("load_error", 32'(load_error), 32'(err_exp));
         if (imem_we) begin
            mem[int'(imem_addr)] = imem_wdata;
            if (exp_wdata.size() == 0) begin
               flag("unexpected_write", $sformatf("got addr 0x%0h data 0x%08h, expected none",
                                                  imem_addr, imem_wdata));
            end else begin
               check("imem_addr", 32'(imem_addr), 32'(exp_waddr.pop_front()));
               check("imem_wdata", imem_wdata, exp_wdata.pop_front());
            end
         end
         if (tx_start) begin
            if (exp_tx.size() == 0) begin
               flag("unexpected_tx", $sformatf("got tx_data 0x%0h, expected none", tx_data));
            end else begin
               check("tx_data", 32'(tx_data), 32'(exp_tx.pop_front()));
            end
         end
      end
      // busy rises one cycle after tx_start is seen, holds, then falls
      if (busy_left > 0) begin
         busy_left--;
         if (busy_left == 0) begin
            tx_busy = 1'b0;
            if (tx_count == 2 && expect_success) run_exp = 1'b1;
         end
      end else if (busy_pend) begin
         busy_pend = 1'b0;
         tx_busy   = 1'b1;
         busy_left = BusyCycles;
      end
      if (tx_start) begin
         busy_pend = 1'b1;
         tx_count++;
      end
   end

   task automatic send_byte(input logic [7:0] b, input bit f);
      @(negedge clk);
      rx_data  = b;
      rx_valid = 1'b1;
      rx_ferr  = f;
   endtask

   task automatic idle(input int n);
      @(negedge clk);
      rx_valid = 1'b0;
      rx_ferr  = 1'b0;
      repeat (n - 1) @(negedge clk);
   endtask

   task automatic wait_tx_idle(input int n);
      int t;
      t = 0;
      while (!(tx_count >= n && !tx_busy && !busy_pend)) begin
         @(negedge clk);
         t++;
         if (t > 400) begin
            flag("tx_wait", $sformatf("got %0d transfers, expected %0d", tx_count, n));
            return;
         end
      end
      @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset_n  = 1'b0;
      rx_valid = 1'b0;
      rx_ferr  = 1'b0;
      rx_data  = 8'd0;
      mon_on   = 1'b0;
      @(posedge clk);
      #2;
      check("rst_tx_data", 32'(tx_data), 32'd0);
      check("rst_tx_start", 32'(tx_start), 32'd0);
      check("rst_imem_we", 32'(imem_we), 32'd0);
      check("rst_imem_addr", 32'(imem_addr), 32'd0);
      check("rst_imem_wdata", imem_wdata, 32'd0);
      check("rst_cpu_run", 32'(cpu_run), 32'd0);
      check("rst_load_error", 32'(load_error), 32'd0);
      @(negedge clk);
      exp_tx.delete();
      exp_waddr.delete();
      exp_wdata.delete();
      exp_tx.push_back(8'h99);
      run_exp        = 1'b0;
      err_exp        = 1'b0;
      expect_success = 1'b0;
      tx_count       = 0;
      reset_n        = 1'b1;
      mon_on         = 1'b1;
      @(posedge clk);
      #2;
      check("tx_start_after_reset", 32'(tx_start), 32'd1);
   endtask

   // One boot attempt. ferr_at / abort_at are program byte indices (-1 = none);
   // the checksum byte sent is XOR(program) ^ csum_delta.
   task automatic load(input logic [31:0] len, input logic [7:0] prog[$], input int ferr_at,
                       input int abort_at, input logic [7:0] csum_delta, input int gap,
                       input bit noise);
      bit         ok;
      bit         success;
      int         n_good;
      logic [7:0] xsum;
      logic [7:0] csum;
      ok     = (len <= MAXB);
      n_good = ok ? int'(len) : 0;
      if (ferr_at >= 0 && ferr_at < n_good) n_good = ferr_at;
      if (abort_at >= 0 && abort_at < n_good) n_good = abort_at;
      xsum = 8'd0;
      for (int k = 0; k < n_good; k++) xsum ^= prog[k];
      csum    = xsum ^ csum_delta;
      success = ok && ferr_at < 0 && abort_at < 0;
`ifdef LOADER_CHECKSUM_EN
      success = success && (csum_delta == 8'd0);
`endif

      do_reset();
      // Whole words among the accepted bytes, plus a zero-filled tail if the image completed.
      for (int w = 0; 4 * w < n_good; w++) begin
         logic [31:0] d;
         d = 32'd0;
         if (4 * w + 3 < n_good || n_good == int'(len)) begin
            for (int i = 0; i < 4; i++) begin
               if (4 * w + i < n_good) d |= 32'(prog[4 * w + i]) << (8 * i);
            end
            exp_waddr.push_back(w);
            exp_wdata.push_back(d);
         end
      end
      if (success) exp_tx.push_back(8'hAA);
      expect_success = success;

      if (noise) begin
         send_byte(8'h55, 1'b0);
         idle(1);
      end
      wait_tx_idle(1);
      for (int i = 0; i < 4; i++) begin
         send_byte(len[8 * i +: 8], 1'b0);
         if (i == 3 && !ok) err_exp = 1'b1;
      end
      if (ok) begin
         for (int k = 0; k < int'(len); k++) begin
            if (k == abort_at) break;
            if (k == ferr_at) begin
               send_byte(prog[k], 1'b1);
               err_exp = 1'b1;
               break;
            end
            send_byte(prog[k], 1'b0);
            if (gap > 0) idle(gap);
         end
`ifdef LOADER_CHECKSUM_EN
         if (ferr_at < 0 && abort_at < 0) begin
            send_byte(csum, 1'b0);
            if (csum != xsum) err_exp = 1'b1;
         end
`endif
      end
      idle(1);
      if (success) wait_tx_idle(2);
      idle(20);
      check("pending_writes", 32'(exp_wdata.size()), 32'd0);
      check("pending_tx", 32'(exp_tx.size()), 32'd0);
      check("final_cpu_run", 32'(cpu_run), 32'(success));
      check("final_load_error", 32'(load_error), 32'(!success && abort_at < 0));
   endtask

   initial begin
      logic [7:0] p[$];

      // Two full words, back to back.
      mem.delete();
      p = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
      load(32'd8, p, -1, -1, 8'h00, 0, 1'b0);
      check("t1_mem0", mem[0], 32'h12345678);
      check("t1_mem1", mem[1], 32'hDEADBEEF);
      // Bytes in RUN are ignored.
      for (int i = 0; i < 3; i++) send_byte(8'(8'hF0 + i), 1'b0);
      idle(5);
      check("run_ignores_rx", 32'(cpu_run), 32'd1);

      // Short final word with gaps, plus a stray byte during 0x99.
      mem.delete();
      p = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
      load(32'd6, p, -1, -1, 8'h00, 1, 1'b1);
      check("t2_mem0", mem[0], 32'h04030201);
      check("t2_mem1", mem[1], 32'h00000605);

      // Final word holding only lane 0.
      mem.delete();
      p = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5};
      load(32'd5, p, -1, -1, 8'h00, 0, 1'b0);
      check("t3_mem1", mem[1], 32'h000000E5);

      // Empty image.
      p.delete();
      load(32'd0, p, -1, -1, 8'h00, 0, 1'b0);

      // Oversize lengths.
      load(MAXB + 1, p, -1, -1, 8'h00, 0, 1'b0);
      load(32'h0100_0000, p, -1, -1, 8'h00, 0, 1'b0);

      // Framing error on program byte 3 (would have completed word 0).
      p = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
      load(32'd8, p, 3, -1, 8'h00, 0, 1'b0);

`ifdef LOADER_CHECKSUM_EN
      p = '{8'h01, 8'h02, 8'h03, 8'h04};
      load(32'd4, p, -1, -1, 8'h00, 0, 1'b0);
      load(32'd4, p, -1, -1, 8'h01, 0, 1'b0);
`endif

      // Reset after 5 of 8 bytes, then a full reload.
      mem.delete();
      p = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hA6, 8'hA7};
      load(32'd8, p, -1, 5, 8'h00, 0, 1'b0);
      p = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h18};
      load(32'd8, p, -1, -1, 8'h00, 0, 1'b0);
      check("reload_words", 32'(mem.num()), 32'd2);
      check("reload_mem0", mem[0], 32'h14131211);
      check("reload_mem1", mem[1], 32'h18171615);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
